// File: rtl/cordic_sched_pkg.sv
// Shared defaults, ID width helper and FSM encoding for the CORDIC request scheduler.
package cordic_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 64;

    // Keeps a one-requester build from collapsing to a zero-width index.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_w(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward (wrapping) and returns
// the first active request as a one-hot grant plus its index.
module rr_arbiter
    import cordic_sched_pkg::*;
#(
    parameter int N = NUM_REQ_DEF
) (
    input  logic [N-1:0]        req,
    input  logic [id_w(N)-1:0]  ptr,
    output logic [N-1:0]        grant,
    output logic [id_w(N)-1:0]  idx
);

    localparam int W = id_w(N);

    always_comb begin
        logic         found;
        logic [W-1:0] cand;
        // NOTE: every output and temporary gets a default first so no path infers a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Time-shares one cordic_top between NUM_REQ requesters: round-robin grant,
// one transaction in flight, completion on the rising edge of cr_done or a timeout.
module cordic_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_mode,
    input  logic [32*NUM_REQ-1:0]      req_theta,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    output logic [id_w(NUM_REQ)-1:0]   rsp_id,
    output logic [31:0]                rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       cr_start,
    output logic                       cr_mode,
    output logic [31:0]                cr_theta,
    input  logic [31:0]                cr_result,
    input  logic                       cr_done
);

    localparam int IW    = id_w(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t             state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      cur_id;
    logic [CNT_W-1:0]   cnt;
    logic               cr_done_q;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IW-1:0]      win_idx;
    logic               done_edge;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (win_onehot),
        .idx   (win_idx)
    );

    // A done level left over from the previous transaction must not complete the next one.
    assign done_edge = cr_done & ~cr_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            cnt       <= '0;
            cr_done_q <= 1'b0;
            gnt       <= '0;
            cr_start  <= 1'b0;
            cr_mode   <= 1'b0;
            cr_theta  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; pulse outputs default low and are raised only where needed.
            cr_done_q <= cr_done;
            gnt       <= '0;
            cr_start  <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req && !cr_done) begin
                        gnt      <= win_onehot;
                        cr_mode  <= req_mode[win_idx];
                        cr_theta <= req_theta[{win_idx, 5'd0} +: 32];
                        cur_id   <= win_idx;
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    cr_start <= 1'b1;
                    cnt      <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_edge) begin
                        rsp_data  <= cr_result;
                        rsp_err   <= 1'b0;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (cur_id == IW'(NUM_REQ - 1)) ? '0 : cur_id + IW'(1);
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler; the bench itself plays cordic_top by driving cr_done/cr_result.
module tb_cordic_scheduler;

    localparam int NR = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] req_mode;
    logic [32*NR-1:0] req_theta;
    logic [NR-1:0] gnt;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          busy;
    logic          cr_start;
    logic          cr_mode;
    logic [31:0]   cr_theta;
    logic [31:0]   cr_result = '0;
    logic          cr_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed operands and expected results: sin30, cos60, sin90, sin(-30) in Q16.
    logic [31:0] theta_tab [NR];
    logic [31:0] res_tab   [NR];
    logic [NR-1:0] mode_tab = 4'b1101;

    cordic_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_mode  (req_mode),
        .req_theta (req_theta),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .cr_start  (cr_start),
        .cr_mode   (cr_mode),
        .cr_theta  (cr_theta),
        .cr_result (cr_result),
        .cr_done   (cr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_ctl"}, {27'd0, cr_start, rsp_valid, rsp_err, busy, cr_mode}, 0);
        check({tag, "_cr_theta"}, cr_theta, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    endtask

    task automatic wait_gnt();
        int k = 0;
        while (gnt == '0 && k < 30) begin
            tick();
            k++;
        end
        check("gnt_seen", 32'(gnt != '0), 1);
    endtask

    function automatic logic within2(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] d;
        d = $signed(a) - $signed(b);
        return (d <= 2) && (d >= -2);
    endfunction

    // One full transaction for requester id; the stub answers lat cycles after cr_start.
    task automatic serve(input int id, input bit hold, input int lat);
        wait_gnt();
        check("gnt_onehot", 32'(gnt), 32'(1) << id);
        check("cr_theta", cr_theta, theta_tab[id]);
        check("cr_mode", 32'(cr_mode), 32'(mode_tab[id]));
        check("busy_on_gnt", {busy, cr_start}, 2'b10);
        if (!hold) req = '0;
        tick();
        check("cr_start", 32'(cr_start), 1);
        repeat (lat) tick();
        cr_result = res_tab[id] - 32'd1;
        cr_done   = 1'b1;
        tick();
        check("rsp_valid", {rsp_valid, rsp_err}, 2'b10);
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_data_tol", 32'(within2(rsp_data, res_tab[id])), 1);
        cr_done = 1'b0;
        tick();
        check("rsp_end", {rsp_valid, busy}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;
        theta_tab = '{32'h001E_0000, 32'h003C_0000, 32'h005A_0000, 32'hFFE2_0000};
        res_tab   = '{32'h0000_8000, 32'h0000_8000, 32'h0001_0000, 32'hFFFF_8000};
        req_mode  = mode_tab;
        for (int i = 0; i < NR; i++) req_theta[32*i +: 32] = theta_tab[i];

        // Reset state
        #12;
        check_reset_vals("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Single request: sin 30 deg
        req = 4'b0001;
        serve(0, 1'b0, 4);

        // Round robin from a fresh pointer with all requests held
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        serve(0, 1'b1, 2);
        serve(1, 1'b1, 2);
        serve(2, 1'b1, 2);
        serve(3, 1'b1, 2);
        serve(0, 1'b0, 2);

        // Stalled cordic: timeout exactly TIMEOUT cycles after cr_start
        req = 4'b0010;
        wait_gnt();
        check("to_gnt", 32'(gnt), 32'b0010);
        req = '0;
        tick();
        check("to_cr_start", 32'(cr_start), 1);
        k = 0;
        do begin
            tick();
            k++;
        end while (!rsp_valid && k < TO + 10);
        check("to_latency", 32'(k), 32'(TO));
        check("to_err", {rsp_valid, rsp_err}, 2'b11);
        check("to_data", rsp_data, 0);
        check("to_id", 32'(rsp_id), 1);
        tick();
        req = 4'b0100;
        serve(2, 1'b0, 3);

        // Reset during WAIT abandons the transaction; arbitration restarts at 0
        req = 4'b0001;
        wait_gnt();
        check("rw_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        tick();
        rst_n = 1'b1;
        cr_result = 32'h0000_5555;
        cr_done = 1'b1;
        seen = 1'b0;
        tick();
        seen |= rsp_valid;
        cr_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= rsp_valid | busy;
        end
        check("rw_no_rsp", 32'(seen), 0);
        req = 4'b1100;
        serve(2, 1'b0, 3);

        // Done edge in the same cycle as the timeout: done wins
        req = 4'b0010;
        wait_gnt();
        check("tie_gnt", 32'(gnt), 32'b0010);
        req = '0;
        tick();
        check("tie_cr_start", 32'(cr_start), 1);
        repeat (TO - 1) tick();
        check("tie_early", 32'(rsp_valid), 0);
        cr_result = 32'h0000_1234;
        cr_done = 1'b1;
        tick();
        check("tie_err", {rsp_valid, rsp_err}, 2'b10);
        check("tie_data", rsp_data, 32'h0000_1234);

        // cr_done still high on return to IDLE: no grant until it falls
        req = 4'b0010;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= (gnt != '0) | busy;
        end
        check("done_hold_no_gnt", 32'(seen), 0);
        cr_done = 1'b0;
        serve(1, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
